// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request side, fixed-latency single-cycle
// response pulse, backed by an internal word array with byte-enabled stores.
//
// state  | meaning
// S_IDLE | ready for a request, no response pending
// S_WAIT | request captured, latency counter running, req_ready low
// S_RESP | rsp_valid pulse; a new request may be accepted in this cycle
module dmem_responder #(
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;

  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;

  logic [31:0]   r_rdata;
  logic          r_rsp_err;
  logic [31:0]   r_mem [DEPTH];

  logic [31:0]   w_off;
  logic          w_req_err;
  logic [AW-1:0] w_req_idx;
  logic          w_accept;
  logic          w_commit;

  logic          w_c_we;
  logic          w_c_err;
  logic [AW-1:0] w_c_idx;
  logic [31:0]   w_c_wdata;
  logic [3:0]    w_c_be;

  // Below-base addresses wrap to large offsets and fall into the range error.
  assign w_off     = req_addr - BASE_ADDR;
  assign w_req_err = (req_addr[1:0] != 2'b00) || (w_off[1:0] != 2'b00) ||
                     (|w_off[31:AW+2]);
  assign w_req_idx = w_off[AW+1:2];

  assign req_ready = (r_state != S_WAIT);
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_rsp_err;

  // With single-cycle latency the commit edge is the accept edge, so the
  // access is taken straight from the request inputs.
  assign w_c_we    = (LATENCY == 1) ? req_we    : r_we;
  assign w_c_err   = (LATENCY == 1) ? w_req_err : r_err;
  assign w_c_idx   = (LATENCY == 1) ? w_req_idx : r_idx;
  assign w_c_wdata = (LATENCY == 1) ? req_wdata : r_wdata;
  assign w_c_be    = (LATENCY == 1) ? req_be    : r_be;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        else          w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_commit = (w_state_nxt == S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rdata   <= '0;
      r_rsp_err <= 1'b0;
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_we    <= req_we;
        r_err   <= w_req_err;
        r_idx   <= w_req_idx;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_commit) begin
        r_rsp_err <= w_c_err;
        if (!w_c_we && !w_c_err) r_rdata <= r_mem[w_c_idx];
      end
    end
  end

  // Array is not reset; reset still blocks a store whose commit edge it hits.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_c_we && !w_c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_c_be[i]) r_mem[w_c_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 1, 2 and 3
// sharing request fields, selected by their own req_valid.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        vld  [3];
  logic        rdy  [3];
  logic        rv   [3];
  logic [31:0] rd   [3];
  logic        re   [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_be(be),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]));

  dmem_responder #(.DEPTH(64), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_be(be),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]));

  dmem_responder #(.DEPTH(64), .LATENCY(3), .BASE_ADDR(32'h0)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(vld[2]), .req_ready(rdy[2]),
    .req_we(we), .req_addr(addr), .req_wdata(wdata), .req_be(be),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(re[2]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance k (latency k+1) and check the wait cycles
  // and the response; returns in the response cycle with req_valid low.
  task automatic xact(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      input logic [31:0] exp_rd, input logic exp_err);
    we = w; addr = a; wdata = d; be = b; vld[k] = 1'b1;
    step();
    vld[k] = 1'b0;
    addr = 32'hFFFF_FFF0;
    wdata = 32'h0;
    for (int c = 1; c <= k; c++) begin
      chk("wait_ready", 32'(rdy[k]), 32'd0);
      chk("wait_valid", 32'(rv[k]), 32'd0);
      step();
    end
    chk("rsp_valid", 32'(rv[k]), 32'd1);
    chk("rsp_ready", 32'(rdy[k]), 32'd1);
    chk("rsp_rdata", rd[k], exp_rd);
    chk("rsp_err", 32'(re[k]), 32'(exp_err));
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = '0;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 32'(rdy[i]), 32'd1);
      chk("rst_valid", 32'(rv[i]), 32'd0);
      chk("rst_rdata", rd[i], 32'd0);
      chk("rst_err", 32'(re[i]), 32'd0);
    end

    // LATENCY=2: store then read back, back-to-back from the RESP cycle
    xact(1, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // byte enables
    xact(1, 1'b1, 32'h10, 32'h11223344, 4'hF, 32'h0, 1'b0);
    xact(1, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // top word, errors, zero-enable store
    xact(1, 1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xact(1, 1'b0, 32'h6, 32'h0, 4'h0, 32'h0, 1'b1);
    xact(1, 1'b1, 32'h100, 32'h12345678, 4'hF, 32'h0, 1'b1);
    xact(1, 1'b1, 32'hFC, 32'h0BADBAD0, 4'h0, 32'h0, 1'b0);
    xact(1, 1'b0, 32'hFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    xact(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    step();
    chk("idle_valid", 32'(rv[1]), 32'd0);
    chk("idle_rdata", rd[1], 32'd0);

    // reset in the WAIT cycle abandons the store
    xact(1, 1'b1, 32'h20, 32'h55555555, 4'hF, 32'h0, 1'b0);
    we = 1'b1; addr = 32'h20; wdata = 32'h99999999; be = 4'hF; vld[1] = 1'b1;
    step();
    vld[1] = 1'b0;
    chk("abort_wait", 32'(rdy[1]), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_ready", 32'(rdy[1]), 32'd1);
    chk("abort_valid", 32'(rv[1]), 32'd0);
    chk("abort_rdata", rd[1], 32'd0);
    chk("abort_err", 32'(re[1]), 32'd0);
    step();
    chk("abort_novalid", 32'(rv[1]), 32'd0);
    xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h55555555, 1'b0);
    step();

    // LATENCY=3: fill four words, then stream four loads with valid held high
    for (int i = 0; i < 4; i++)
      xact(2, 1'b1, 32'h40 + 32'(4*i), 32'hA000_0001 + 32'(i), 4'hF, 32'h0, 1'b0);
    step();
    we = 1'b0; addr = 32'h40; vld[2] = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      addr = 32'h40 + 32'(4*(i+1));
      chk("b2b_w1_ready", 32'(rdy[2]), 32'd0);
      chk("b2b_w1_valid", 32'(rv[2]), 32'd0);
      step();
      chk("b2b_w2_ready", 32'(rdy[2]), 32'd0);
      chk("b2b_w2_valid", 32'(rv[2]), 32'd0);
      step();
      chk("b2b_valid", 32'(rv[2]), 32'd1);
      chk("b2b_ready", 32'(rdy[2]), 32'd1);
      chk("b2b_rdata", rd[2], 32'hA000_0001 + 32'(i));
      if (i == 3) vld[2] = 1'b0;
      step();
    end
    chk("b2b_end_valid", 32'(rv[2]), 32'd0);
    chk("b2b_end_ready", 32'(rdy[2]), 32'd1);

    // LATENCY=1: one response per cycle sustained
    xact(0, 1'b1, 32'h0, 32'h13579BDF, 4'hF, 32'h0, 1'b0);
    xact(0, 1'b1, 32'h4, 32'h2468ACE0, 4'hF, 32'h0, 1'b0);
    we = 1'b0; addr = 32'h0; vld[0] = 1'b1;
    step();
    chk("l1_valid0", 32'(rv[0]), 32'd1);
    chk("l1_rdata0", rd[0], 32'h13579BDF);
    addr = 32'h4;
    step();
    chk("l1_valid1", 32'(rv[0]), 32'd1);
    chk("l1_rdata1", rd[0], 32'h2468ACE0);
    addr = 32'h102;
    step();
    chk("l1_valid2", 32'(rv[0]), 32'd1);
    chk("l1_err2", 32'(re[0]), 32'd1);
    chk("l1_rdata2", rd[0], 32'd0);
    vld[0] = 1'b0;
    step();
    chk("l1_idle", 32'(rv[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
